// File: rtl/clock_ctrl.sv
// clock_ctrl: 24-hour HH:MM:SS BCD clock with 1 Hz prescaler and button-driven set modes.
module clock_ctrl #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rs_n,
  input  logic       mode_p,
  input  logic       inc_p,
  output logic [3:0] sec_u,
  output logic [3:0] sec_t,
  output logic [3:0] min_u,
  output logic [3:0] min_t,
  output logic [3:0] hr_u,
  output logic [3:0] hr_t,
  output logic [1:0] mode,
  output logic       tick_1hz,
  output logic       blink
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PC_HALF = PW'(TICK_DIV / 2);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10,
    ILLEGAL = 2'b11
  } mode_t;

  mode_t         r_mode, w_mode_nx;
  logic [PW-1:0] r_pc, w_pc_nx;
  logic [7:0]    r_sec, r_min, r_hr;
  logic [7:0]    w_sec_nx, w_min_nx, w_hr_nx;
  logic          r_tick, r_blink, w_blink_nx;
  logic          w_tick;
  logic [8:0]    w_sec_inc, w_min_inc;
  logic [7:0]    w_hr_inc;

  // Mod-60 BCD increment of a tens/units pair; MSB is the carry out.
  function automatic logic [8:0] inc60(input logic [3:0] t, input logic [3:0] u);
    if (u != 4'd9)      return {1'b0, t, u + 4'd1};
    else if (t != 4'd5) return {1'b0, t + 4'd1, 4'd0};
    else                return 9'd0 | 9'h100;
  endfunction

  // Mod-24 BCD increment of the hours pair.
  function automatic logic [7:0] inc24(input logic [3:0] t, input logic [3:0] u);
    if (t == 4'd2 && u == 4'd3) return 8'd0;
    else if (u == 4'd9)         return {t + 4'd1, 4'd0};
    else                        return {t, u + 4'd1};
  endfunction

  // Next-state for prescaler, digits, mode and blink.
  always_comb begin
    w_mode_nx = r_mode;
    w_sec_nx  = r_sec;
    w_min_nx  = r_min;
    w_hr_nx   = r_hr;
    w_tick    = (r_pc == PC_MAX);
    w_pc_nx   = w_tick ? '0 : r_pc + PW'(1);
    w_sec_inc = inc60(r_sec[7:4], r_sec[3:0]);
    w_min_inc = inc60(r_min[7:4], r_min[3:0]);
    w_hr_inc  = inc24(r_hr[7:4], r_hr[3:0]);
    case (r_mode)
      RUN: begin
        if (w_tick) begin
          w_sec_nx = w_sec_inc[7:0];
          if (w_sec_inc[8]) begin
            w_min_nx = w_min_inc[7:0];
            if (w_min_inc[8]) w_hr_nx = w_hr_inc;
          end
        end
        if (mode_p) w_mode_nx = SET_HR;
      end
      SET_HR: begin
        if (mode_p)     w_mode_nx = SET_MIN;
        else if (inc_p) w_hr_nx   = w_hr_inc;
      end
      SET_MIN: begin
        if (mode_p) begin
          // Leaving set mode restarts the current second.
          w_mode_nx = RUN;
          w_sec_nx  = 8'd0;
          w_pc_nx   = '0;
        end else if (inc_p) begin
          w_min_nx = w_min_inc[7:0];
        end
      end
      default: w_mode_nx = RUN;
    endcase
    w_blink_nx = (w_mode_nx == RUN) || (w_pc_nx < PC_HALF);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      r_mode  <= RUN;
      r_pc    <= '0;
      r_sec   <= 8'd0;
      r_min   <= 8'd0;
      r_hr    <= 8'd0;
      r_tick  <= 1'b0;
      r_blink <= 1'b1;
    end else begin
      r_mode  <= w_mode_nx;
      r_pc    <= w_pc_nx;
      r_sec   <= w_sec_nx;
      r_min   <= w_min_nx;
      r_hr    <= w_hr_nx;
      r_tick  <= w_tick;
      r_blink <= w_blink_nx;
    end
  end

  assign sec_u    = r_sec[3:0];
  assign sec_t    = r_sec[7:4];
  assign min_u    = r_min[3:0];
  assign min_t    = r_min[7:4];
  assign hr_u     = r_hr[3:0];
  assign hr_t     = r_hr[7:4];
  assign mode     = r_mode;
  assign tick_1hz = r_tick;
  assign blink    = r_blink;

endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: randomized and directed checks of clock_ctrl against a seconds-of-day model.
module tb_clock_ctrl;

  localparam int TD = 4;

  logic       clk, rs_n, mode_p, inc_p;
  logic [3:0] sec_u, sec_t, min_u, min_t, hr_u, hr_t;
  logic [1:0] mode;
  logic       tick_1hz, blink;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: time as seconds of day, mode as 0/1/2, prescaler count.
  int m_t, m_mode, m_pc;
  logic m_tick, m_blink;

  clock_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rs_n(rs_n), .mode_p(mode_p), .inc_p(inc_p),
    .sec_u(sec_u), .sec_t(sec_t), .min_u(min_u), .min_t(min_t),
    .hr_u(hr_u), .hr_t(hr_t), .mode(mode), .tick_1hz(tick_1hz), .blink(blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] bcd(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] disp();
    return {hr_t, hr_u, min_t, min_u, sec_t, sec_u};
  endfunction

  task automatic model_reset();
    m_t = 0; m_mode = 0; m_pc = 0; m_tick = 1'b0; m_blink = 1'b1;
  endtask

  // One clock edge of the behavioural clock, given the sampled buttons.
  task automatic model_edge(input logic mp, input logic ip);
    int h, m, s;
    logic tk;
    tk = (m_pc == TD - 1);
    h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
    m_pc = tk ? 0 : m_pc + 1;
    case (m_mode)
      0: begin
        if (tk) m_t = (m_t + 1) % 86400;
        if (mp) m_mode = 1;
      end
      1: begin
        if (mp) m_mode = 2;
        else if (ip) m_t = ((h + 1) % 24) * 3600 + m * 60 + s;
      end
      default: begin
        if (mp) begin
          m_mode = 0;
          m_t = h * 3600 + m * 60;
          m_pc = 0;
        end else if (ip) begin
          m_t = h * 3600 + ((m + 1) % 60) * 60 + s;
        end
      end
    endcase
    m_tick = tk;
    m_blink = (m_mode == 0) || (m_pc < TD / 2);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".time"}, 32'(disp()), 32'(bcd(m_t)));
    check({tag, ".mode"}, 32'(mode), 32'(m_mode));
    check({tag, ".tick"}, 32'(tick_1hz), 32'(m_tick));
    check({tag, ".blink"}, 32'(blink), 32'(m_blink));
  endtask

  // Drive buttons away from the edge, clock once, compare after the edge.
  task automatic step(input logic mp, input logic ip);
    mode_p = mp; inc_p = ip;
    @(posedge clk);
    model_edge(mp, ip);
    #1;
    mode_p = 1'b0; inc_p = 1'b0;
    check_all("cyc");
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic presses(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  // Asynchronous reset between edges; called just after a sampling point.
  task automatic async_reset(input string tag);
    #2 rs_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".time"}, 32'(disp()), 32'd0);
    check({tag, ".mode"}, 32'(mode), 32'd0);
    check({tag, ".tick"}, 32'(tick_1hz), 32'd0);
    check({tag, ".blink"}, 32'(blink), 32'd1);
    rs_n = 1'b1;
  endtask

  initial begin
    rs_n = 1'b0; mode_p = 1'b0; inc_p = 1'b0;
    model_reset();
    #23;
    check_all("por");
    rs_n = 1'b1;

    // Set 12:34 then run to 12:34:56, then reset mid-count.
    step(1'b1, 1'b0); presses(12);
    step(1'b1, 1'b0); presses(34);
    step(1'b1, 1'b0);
    steps(224);
    check("set_run", 32'(disp()), 32'h123456);
    async_reset("rst_mid");
    steps(4);
    check("first_tick", 32'(disp()), 32'h000001);
    steps(236);
    check("one_min", 32'(disp()), 32'h000100);

    // Full day wrap.
    async_reset("rst_wrap");
    step(1'b1, 1'b0); presses(23);
    step(1'b1, 1'b0); presses(59);
    step(1'b1, 1'b0);
    check("exit_sec", 32'(disp()), 32'h235900);
    steps(236);
    check("pre_wrap", 32'(disp()), 32'h235959);
    steps(4);
    check("day_wrap", 32'(disp()), 32'h000000);
    check("wrap_tick", 32'(tick_1hz), 32'd1);

    // Wrapping while setting.
    async_reset("rst_set");
    step(1'b1, 1'b0); presses(24);
    check("hr_wrap", 32'(disp()), 32'h000000);
    presses(5);
    step(1'b1, 1'b0); presses(61);
    check("min_wrap", 32'(disp()), 32'h050100);
    step(1'b1, 1'b0);
    check("set_exit_mode", 32'(mode), 32'd0);

    // Simultaneous events.
    async_reset("rst_conf");
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("mode_wins", 32'(mode), 32'd2);
    check("mode_wins_hr", 32'(disp()), 32'h000000);
    step(1'b1, 1'b0);
    steps(12);
    while (m_pc != TD - 1) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("tick_mode", 32'(disp()), 32'h000004);
    check("tick_mode_m", 32'(mode), 32'd1);
    steps(80);
    check("frozen_sec", 32'(disp()), 32'h000004);
    step(1'b1, 1'b0);
    while (m_pc != TD - 1) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("exit_on_tick", 32'(disp()), 32'h000000);

    // Randomized buttons.
    for (int i = 0; i < 4000; i++)
      step(1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 2) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
